// File: rtl/urx_param.sv
// rtl/urx_param.sv - parametrised oversampling UART receiver with valid/ready output
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   rx         asynchronous serial line, idle high
//   rx_data    received word, LSB is the first bit on the line
//   rx_valid   rx_data and error flags valid, held until accepted
//   rx_ready   consumer accepts the word when rx_valid & rx_ready
//   parity_err parity mismatch for the presented word
//   frame_err  a stop bit was sampled low for the presented word
//   overrun    sticky: a completed frame was dropped while rx_valid was held
//   busy       receiver is not idle
module urx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state;
    state_t               state_n;
    logic                 rx_meta;
    logic                 rxs;
    logic [CW-1:0]        clkcnt;
    logic [BW-1:0]        bitidx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic                 at_centre;
    logic                 done;
    logic                 accept;

    assign at_centre = (clkcnt == CNT_LAST);
    assign busy      = (state != IDLE);
    // A finished word may load if the output slot is empty or being emptied this edge.
    assign accept    = done && (!rx_valid || rx_ready);

    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) state_n = START;
            end
            START: begin
                if (rxs)                     state_n = IDLE;
                else if (clkcnt == CNT_HALF) state_n = DATA;
            end
            DATA: begin
                if (at_centre && bitidx == DATA_LAST)
                    state_n = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY: begin
                if (at_centre) state_n = STOP;
            end
            STOP: begin
                if (at_centre && bitidx == STOP_LAST) begin
                    done = 1'b1;
                    // A low stop bit may be the start of a break; do not re-arm until high.
                    state_n = (frm_err_q || !rxs) ? WAIT_HIGH : IDLE;
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            state      <= IDLE;
            clkcnt     <= '0;
            bitidx     <= '0;
            shreg      <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            state   <= state_n;

            if (state_n != state || state == IDLE || state == WAIT_HIGH)
                clkcnt <= '0;
            else if (at_centre)
                clkcnt <= '0;
            else
                clkcnt <= clkcnt + 1'b1;

            // bitidx counts data samples in DATA and stop samples in STOP.
            if (state_n != state)
                bitidx <= '0;
            else if (at_centre)
                bitidx <= bitidx + 1'b1;

            if (state == DATA && at_centre)
                shreg <= {rxs, shreg[DATA_BITS-1:1]};

            if (state == IDLE) begin
                par_err_q <= 1'b0;
                frm_err_q <= 1'b0;
            end
            if (state == PARITY && at_centre)
                par_err_q <= ((^shreg) ^ rxs) != ODD;
            if (state == STOP && at_centre && !rxs)
                frm_err_q <= 1'b1;

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            if (accept) begin
                rx_data    <= shreg;
                parity_err <= par_err_q;
                frame_err  <= frm_err_q | ~rxs;
                rx_valid   <= 1'b1;
            end else if (done) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_urx_param.sv
// tb/tb_urx_param.sv - randomized and directed checks of urx_param against a frame-level model
module tb_urx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] rxl = 4'hF;
    logic [3:0] rdy = 4'hF;
    logic [3:0] vld;
    logic [3:0] pe;
    logic [3:0] fe;
    logic [3:0] ovr;
    logic [3:0] bsy;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [8:0] d3;

    // Instance formats: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 9N2
    int nb [4] = '{8, 8, 8, 9};
    int pm [4] = '{0, 1, 2, 0};
    int ns [4] = '{1, 1, 1, 2};

    typedef struct {
        int k;
        int data;
        int perr;
        int ferr;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   errors   = 0;
    int   accepted = 0;
    bit   rand_rdy = 1'b0;

    always #5 clk = ~clk;

    urx_param u_8n1 (
        .clk(clk), .rst(rst), .rx(rxl[0]), .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ovr[0]), .busy(bsy[0]));
    urx_param #(.PARITY_MODE(1)) u_8e1 (
        .clk(clk), .rst(rst), .rx(rxl[1]), .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ovr[1]), .busy(bsy[1]));
    urx_param #(.PARITY_MODE(2)) u_8o1 (
        .clk(clk), .rst(rst), .rx(rxl[2]), .rx_data(d2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ovr[2]), .busy(bsy[2]));
    urx_param #(.DATA_BITS(9), .STOP_BITS(2)) u_9n2 (
        .clk(clk), .rst(rst), .rx(rxl[3]), .rx_data(d3), .rx_valid(vld[3]), .rx_ready(rdy[3]),
        .parity_err(pe[3]), .frame_err(fe[3]), .overrun(ovr[3]), .busy(bsy[3]));

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int get_data(input int k);
        case (k)
            0:       return int'(d0);
            1:       return int'(d1);
            2:       return int'(d2);
            default: return int'(d3);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rdy = 4'($urandom);
    endtask

    task automatic drive_bit(input int k, input int b);
        rxl[k] = b[0];
        repeat (16) tick();
    endtask

    // Builds a frame from the line rules: start 0, data LSB first, parity so the
    // ones-count of data+parity is even/odd, then stop bits (high unless forced low).
    task automatic send_frame(input int k, input int data, input bit flip, input int slm,
                              input int gap, input bit push);
        int   d;
        int   p;
        exp_t e;
        d = data & ((1 << nb[k]) - 1);
        if (push) begin
            e.k    = k;
            e.data = d;
            e.perr = (pm[k] != 0 && flip) ? 1 : 0;
            e.ferr = ((slm & ((1 << ns[k]) - 1)) != 0) ? 1 : 0;
            expq.push_back(e);
        end
        drive_bit(k, 0);
        for (int i = 0; i < nb[k]; i++) drive_bit(k, (d >> i) & 1);
        if (pm[k] != 0) begin
            p = ($countones(d) % 2) ^ ((pm[k] == 2) ? 1 : 0) ^ (flip ? 1 : 0);
            drive_bit(k, p);
        end
        for (int i = 0; i < ns[k]; i++) drive_bit(k, ((slm >> i) & 1) != 0 ? 0 : 1);
        if (gap > 0) begin
            rxl[k] = 1'b1;
            repeat (gap) tick();
        end
    endtask

    // Every word taken by the consumer must match the oldest outstanding model word.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst && vld[k] && rdy[k]) begin
                accepted++;
                if (expq.size() == 0) begin
                    check("spurious_word", k, -1);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("word_dut", k, e.k);
                    check("word_data", get_data(k), e.data);
                    check("word_parity_err", int'(pe[k]), e.perr);
                    check("word_frame_err", int'(fe[k]), e.ferr);
                end
            end
        end
    end

    initial begin
        int acc0;
        int gap;
        int slm;
        bit flip;

        repeat (3) tick();
        check("rst_valid", int'(vld), 0);
        check("rst_busy", int'(bsy), 0);
        check("rst_overrun", int'(ovr), 0);
        check("rst_data0", int'(d0), 0);
        check("rst_data3", int'(d3), 0);
        check("rst_flags", int'({pe, fe}), 0);
        rst = 1'b1;
        repeat (4) tick();

        // 8N1 single word
        acc0 = accepted;
        send_frame(0, 'hA5, 1'b0, 0, 40, 1'b1);
        check("8n1_count", accepted - acc0, 1);
        check("8n1_valid_low", int'(vld[0]), 0);

        // Parity builds, correct then flipped
        send_frame(1, 'h37, 1'b0, 0, 30, 1'b1);
        send_frame(1, 'h37, 1'b1, 0, 30, 1'b1);
        send_frame(2, 'h37, 1'b0, 0, 30, 1'b1);
        send_frame(2, 'h37, 1'b1, 0, 30, 1'b1);
        check("parity_pending", expq.size(), 0);

        // Glitch shorter than half a bit
        acc0 = accepted;
        rxl[0] = 1'b0;
        repeat (5) tick();
        check("glitch_busy_hi", int'(bsy[0]), 1);
        rxl[0] = 1'b1;
        repeat (40) tick();
        check("glitch_busy_lo", int'(bsy[0]), 0);
        check("glitch_count", accepted - acc0, 0);

        // Framing error followed by a long break
        acc0 = accepted;
        send_frame(0, 'h55, 1'b0, 1, 0, 1'b1);
        rxl[0] = 1'b0;
        repeat (200) tick();
        check("break_count", accepted - acc0, 1);
        check("break_busy", int'(bsy[0]), 1);
        rxl[0] = 1'b1;
        repeat (20) tick();
        check("break_idle", int'(bsy[0]), 0);
        send_frame(0, 'h3C, 1'b0, 0, 30, 1'b1);
        check("break_recover", accepted - acc0, 2);

        // Overrun: two back-to-back words with nobody accepting
        rdy[0] = 1'b0;
        send_frame(0, 'h11, 1'b0, 0, 0, 1'b1);
        send_frame(0, 'h22, 1'b0, 0, 20, 1'b0);
        check("ovr_valid", int'(vld[0]), 1);
        check("ovr_data", int'(d0), 'h11);
        check("ovr_flag", int'(ovr[0]), 1);
        rdy[0] = 1'b1;
        tick();
        tick();
        check("ovr_valid_clr", int'(vld[0]), 0);
        check("ovr_flag_clr", int'(ovr[0]), 0);

        // Reset in the middle of a 9N2 frame after the third data bit
        acc0 = accepted;
        drive_bit(3, 0);
        for (int i = 0; i < 3; i++) drive_bit(3, ('h0AA >> i) & 1);
        rst = 1'b0;
        rxl[3] = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        check("midrst_busy", int'(bsy[3]), 0);
        check("midrst_valid", int'(vld[3]), 0);
        repeat (10) tick();
        send_frame(3, 'h1C3, 1'b0, 0, 40, 1'b1);
        check("midrst_count", accepted - acc0, 1);

        // Randomized frames on every format with random consumer back-pressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 10; n++) begin
                flip = (pm[k] != 0) && ($urandom_range(0, 3) == 0);
                slm  = ($urandom_range(0, 3) == 0) ? ((ns[k] == 2) ? $urandom_range(1, 3) : 1) : 0;
                gap  = (slm != 0) ? 16 + $urandom_range(0, 8) : $urandom_range(0, 20);
                send_frame(k, int'($urandom), flip, slm, gap, 1'b1);
            end
        end
        rand_rdy = 1'b0;
        rdy = 4'hF;
        repeat (40) tick();
        check("rand_pending", expq.size(), 0);
        check("rand_overrun", int'(ovr), 0);
        check("rand_idle", int'(bsy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
